// File: rtl/iob_eth_tx_frame_src_pkg.sv
// ============================================================================
// Module  : iob_eth_tx_frame_src_pkg
// Brief   : Shared Ethernet TX constants, FSM and read-select encodings.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package iob_eth_tx_frame_src_pkg;

    localparam int         c_preamble_len  = 7;
    localparam logic [7:0] c_preamble_byte = 8'h55;
    localparam logic [7:0] c_sfd_byte      = 8'hD5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_PAD    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LAUNCH = 3'd4,
        ST_BUSY   = 3'd5
    } state_t;

    // Source of the byte returned on the transmitter read port
    typedef enum logic [1:0] {
        RSEL_ZERO = 2'd0,
        RSEL_PRE  = 2'd1,
        RSEL_SFD  = 2'd2,
        RSEL_RAM  = 2'd3
    } rsel_t;

endpackage

`default_nettype wire

// File: rtl/iob_eth_tx_buf.sv
// ============================================================================
// Module  : iob_eth_tx_buf
// Brief   : Simple dual-port byte RAM, one write port, one registered read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_eth_tx_buf #(
    parameter int BUF_AW = 11
) (
    input  logic              TX_CLK,
    input  logic              i_we,
    input  logic [BUF_AW-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [BUF_AW-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [2**BUF_AW];
    logic [7:0] r_rdata;

    always_ff @(posedge TX_CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/iob_eth_tx_frame_src.sv
// ============================================================================
// Module  : iob_eth_tx_frame_src
// Brief   : TX_CLK-domain frame buffer feeding the MII transmitter; serves
//           preamble/SFD + frame bytes. Define IOB_ETH_TX_PAD_EN to zero-pad
//           short frames to MIN_FRAME.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_eth_tx_frame_src
    import iob_eth_tx_frame_src_pkg::*;
#(
    parameter int BUF_AW    = 11,
    parameter int MIN_FRAME = 60
) (
    input  logic              TX_CLK,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              overflow,
    output logic              send,
    input  logic              tx_ready,
    input  logic [BUF_AW-1:0] addr,
    output logic [7:0]        data,
    output logic [BUF_AW-1:0] nbytes
);

    localparam logic [BUF_AW:0]   c_wptr_start = (BUF_AW+1)'(c_preamble_len + 1);
    localparam logic [BUF_AW:0]   c_min_frame  = (BUF_AW+1)'(MIN_FRAME);
    localparam logic [BUF_AW-1:0] c_pre_len    = BUF_AW'(c_preamble_len);

    state_t            r_state, w_state_nxt;
    logic [BUF_AW:0]   r_wptr, w_wptr_nxt;
    logic [BUF_AW-1:0] r_nbytes, w_nbytes_nxt;
    logic              r_overflow, w_overflow_nxt;
    logic              r_settle_cnt, w_settle_cnt_nxt;
    logic              r_in_ready;
    logic              r_send;
    rsel_t             r_rsel, w_rsel;

    logic              w_accept;
    logic              w_full;
    logic              w_pad_needed;
    logic              w_we;
    logic [7:0]        w_wdata;
    logic [7:0]        w_ram_q;
    logic [BUF_AW:0]   w_frame_len;

    function automatic logic [BUF_AW-1:0] sat_len(input logic [BUF_AW:0] v);
        return v[BUF_AW] ? '1 : v[BUF_AW-1:0];
    endfunction

    assign w_accept     = in_valid & r_in_ready;
    assign w_full       = r_wptr[BUF_AW];
    assign w_frame_len  = r_wptr - c_wptr_start;
    assign w_pad_needed = (w_frame_len < c_min_frame);

    always_comb begin
        w_state_nxt      = r_state;
        w_wptr_nxt       = r_wptr;
        w_nbytes_nxt     = r_nbytes;
        w_overflow_nxt   = r_overflow;
        w_settle_cnt_nxt = r_settle_cnt;
        w_we             = 1'b0;
        w_wdata          = in_data;

        case (r_state)
            ST_IDLE, ST_FILL: begin
                if (w_accept) begin
                    if (r_state == ST_IDLE) begin
                        w_overflow_nxt = 1'b0;
                        w_state_nxt    = ST_FILL;
                    end
                    if (w_full) begin
                        w_overflow_nxt = 1'b1;
                    end else begin
                        w_we       = 1'b1;
                        w_wptr_nxt = r_wptr + 1'b1;
                    end
                    if (in_last) begin
`ifdef IOB_ETH_TX_PAD_EN
                        w_state_nxt      = ST_PAD;
`else
                        w_state_nxt      = ST_SETTLE;
                        w_nbytes_nxt     = sat_len(w_wptr_nxt);
                        w_settle_cnt_nxt = 1'b0;
`endif
                    end
                end
            end

            ST_PAD: begin
                if (w_pad_needed && !w_full) begin
                    w_we       = 1'b1;
                    w_wdata    = 8'h00;
                    w_wptr_nxt = r_wptr + 1'b1;
                end else begin
                    w_nbytes_nxt     = sat_len(r_wptr);
                    w_settle_cnt_nxt = 1'b0;
                    w_state_nxt      = ST_SETTLE;
                end
            end

            // Two idle cycles let the transmitter's nbytes synchroniser settle
            ST_SETTLE: begin
                if (r_settle_cnt) begin
                    w_state_nxt = ST_LAUNCH;
                end else begin
                    w_settle_cnt_nxt = 1'b1;
                end
            end

            ST_LAUNCH: begin
                if (!tx_ready) begin
                    w_state_nxt = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (tx_ready) begin
                    w_wptr_nxt  = c_wptr_start;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_wptr_nxt  = c_wptr_start;
            end
        endcase
    end

    always_ff @(posedge TX_CLK or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wptr       <= c_wptr_start;
            r_nbytes     <= '0;
            r_overflow   <= 1'b0;
            r_settle_cnt <= 1'b0;
            r_in_ready   <= 1'b0;
            r_send       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wptr       <= w_wptr_nxt;
            r_nbytes     <= w_nbytes_nxt;
            r_overflow   <= w_overflow_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_in_ready   <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_FILL);
            r_send       <= (w_state_nxt == ST_LAUNCH);
        end
    end

    // Preamble/SFD are synthesised here rather than stored in the RAM
    always_comb begin
        if (addr < c_pre_len) begin
            w_rsel = RSEL_PRE;
        end else if (addr == c_pre_len) begin
            w_rsel = RSEL_SFD;
        end else begin
            w_rsel = RSEL_RAM;
        end
    end

    always_ff @(posedge TX_CLK or posedge rst) begin
        if (rst) begin
            r_rsel <= RSEL_ZERO;
        end else begin
            r_rsel <= w_rsel;
        end
    end

    iob_eth_tx_buf #(
        .BUF_AW (BUF_AW)
    ) u_buf (
        .TX_CLK  (TX_CLK),
        .i_we    (w_we),
        .i_waddr (r_wptr[BUF_AW-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (addr),
        .o_rdata (w_ram_q)
    );

    always_comb begin
        case (r_rsel)
            RSEL_PRE: data = c_preamble_byte;
            RSEL_SFD: data = c_sfd_byte;
            RSEL_RAM: data = w_ram_q;
            default:  data = 8'h00;
        endcase
    end

    assign in_ready = r_in_ready;
    assign send     = r_send;
    assign overflow = r_overflow;
    assign nbytes   = r_nbytes;

endmodule

`default_nettype wire
